// File: rtl/game_pkg.sv
// Shared types, constants and digit-set helpers for the 1A2B guess scorer.
package game_pkg;

  typedef enum logic [1:0] {GEN, INPUT, SCORE, WIN} state_e;

  localparam logic [3:0]  BLANK_DIGIT = 4'hF;
  localparam int unsigned NUM_DIGITS  = 4;

  // True if d occurs among the first n digits of v (first digit at [15:12]).
  function automatic logic digit_seen(logic [15:0] v, logic [2:0] n, logic [3:0] d);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (3'(i) < n && v[15-4*i -: 4] == d) hit = 1'b1;
    end
    return hit;
  endfunction

  // All four digits are BCD and pairwise distinct.
  function automatic logic secret_ok(logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[15-4*i -: 4] > 4'd9 || digit_seen(v, 3'(i), v[15-4*i -: 4])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/guess_scorer_if.sv
// Strobe/data bundle between the digit predictor, the scorer and the display driver.
interface guess_scorer_if;
  import game_pkg::*;

  logic        digit_valid;
  logic [3:0]  digit_in;
  logic        commit;
  logic        clear;
  logic        new_game;
  logic        secret_load;
  logic [15:0] secret_in;
  logic [3:0]  disp_digit;
  logic [2:0]  a_count;
  logic [2:0]  b_count;
  logic        result_valid;
  logic [6:0]  guess_cnt;
  logic        win;
  logic        reject;
  logic [15:0] secret_out;
  logic        busy;

  modport master (
    output digit_valid, digit_in, commit, clear, new_game, secret_load, secret_in,
    input  disp_digit, a_count, b_count, result_valid, guess_cnt, win, reject,
           secret_out, busy
  );

  modport slave (
    input  digit_valid, digit_in, commit, clear, new_game, secret_load, secret_in,
    output disp_digit, a_count, b_count, result_valid, guess_cnt, win, reject,
           secret_out, busy
  );
endinterface

// File: rtl/ab_compare.sv
// Combinational A/B scoring of two 4-digit BCD words whose digits are distinct.
module ab_compare
  import game_pkg::*;
(
  input  logic [15:0] secret,
  input  logic [15:0] guess,
  output logic [2:0]  a,
  output logic [2:0]  b
);

  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (secret[4*i +: 4] == guess[4*j +: 4]) begin
          if (i == j) a = a + 3'd1;
          else        b = b + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/guess_scorer.sv
// Secret generation, guess entry and scoring for the handwritten 1A2B game.
module guess_scorer
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned MAX_GUESSES = 99
) (
  input logic          clk,
  input logic          rst_n,
  guess_scorer_if.slave gif
);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, secret_q, secret_d, buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  disp_q, disp_d, cand;
  logic [2:0]  a_q, a_d, b_q, b_d, cmp_a, cmp_b;
  logic [6:0]  gcnt_q, gcnt_d;
  logic        rv_q, rv_d, win_q, win_d, rej_q, rej_d, load_ok;

  ab_compare u_cmp (
    .secret (secret_q),
    .guess  (buf_q),
    .a      (cmp_a),
    .b      (cmp_b)
  );

  assign load_ok = gif.secret_load && secret_ok(gif.secret_in);
  assign cand    = lfsr_q[3:0];

  // cnt_q counts secret digits in GEN and guess digits in INPUT.
  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    a_d      = a_q;
    b_d      = b_q;
    rv_d     = 1'b0;
    gcnt_d   = gcnt_q;
    win_d    = win_q;
    rej_d    = 1'b0;
    if (load_ok || gif.new_game) begin
      state_d  = load_ok ? INPUT : GEN;
      secret_d = load_ok ? gif.secret_in : '0;
      buf_d    = '0;
      cnt_d    = '0;
      gcnt_d   = '0;
      a_d      = '0;
      b_d      = '0;
      win_d    = 1'b0;
      disp_d   = BLANK_DIGIT;
    end else begin
      unique case (state_q)
        GEN: begin
          if (cand <= 4'd9 && !digit_seen(secret_q, cnt_q, cand)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (cnt_q == 3'(i)) secret_d[15-4*i -: 4] = cand;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(NUM_DIGITS - 1)) begin
              state_d = INPUT;
              cnt_d   = '0;
            end
          end
        end
        INPUT: begin
          if (gif.clear) begin
            cnt_d  = '0;
            disp_d = BLANK_DIGIT;
          end else if (gif.commit) begin
            // Result is latched here so result_valid shows during the SCORE cycle.
            if (cnt_q == 3'(NUM_DIGITS)) begin
              state_d = SCORE;
              a_d     = cmp_a;
              b_d     = cmp_b;
              rv_d    = 1'b1;
              gcnt_d  = (gcnt_q == 7'(MAX_GUESSES)) ? gcnt_q : gcnt_q + 7'd1;
              win_d   = (cmp_a == 3'(NUM_DIGITS));
            end
          end else if (gif.digit_valid) begin
            if (gif.digit_in <= 4'd9 && cnt_q < 3'(NUM_DIGITS) &&
                !digit_seen(buf_q, cnt_q, gif.digit_in)) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cnt_q == 3'(i)) buf_d[15-4*i -: 4] = gif.digit_in;
              end
              cnt_d  = cnt_q + 3'd1;
              disp_d = gif.digit_in;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        SCORE: begin
          if (win_q) begin
            state_d = WIN;
          end else begin
            state_d = INPUT;
            buf_d   = '0;
            cnt_d   = '0;
            disp_d  = BLANK_DIGIT;
          end
        end
        WIN: ;
        default: state_d = GEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GEN;
      lfsr_q   <= LFSR_SEED;
      secret_q <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= BLANK_DIGIT;
      a_q      <= '0;
      b_q      <= '0;
      rv_q     <= 1'b0;
      gcnt_q   <= '0;
      win_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      secret_q <= secret_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rv_q     <= rv_d;
      gcnt_q   <= gcnt_d;
      win_q    <= win_d;
      rej_q    <= rej_d;
    end
  end

  assign gif.disp_digit   = disp_q;
  assign gif.a_count      = a_q;
  assign gif.b_count      = b_q;
  assign gif.result_valid = rv_q;
  assign gif.guess_cnt    = gcnt_q;
  assign gif.win          = win_q;
  assign gif.reject       = rej_q;
  assign gif.secret_out   = secret_q;
  assign gif.busy         = (state_q == GEN) || (state_q == SCORE);

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: directed game scenarios plus randomized scoring.
module tb_guess_scorer;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] m_secret;
  int          m_gcnt;

  always #5 clk = ~clk;

  guess_scorer_if gif ();

  guess_scorer #(.LFSR_SEED(16'hACE1), .MAX_GUESSES(99)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gif   (gif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference scoring: A by position, B = shared digit set size minus A.
  function automatic void model_score(input logic [15:0] s, input logic [15:0] g,
                                      output int a, output int b);
    bit [9:0] in_s, in_g;
    int ds, dg;
    in_s = '0;
    in_g = '0;
    a = 0;
    for (int i = 0; i < 4; i++) begin
      ds = int'((s >> (12 - 4 * i)) & 16'hF);
      dg = int'((g >> (12 - 4 * i)) & 16'hF);
      if (ds == dg) a++;
      in_s[ds] = 1'b1;
      in_g[dg] = 1'b1;
    end
    b = $countones(in_s & in_g) - a;
  endfunction

  function automatic bit model_valid(input logic [15:0] v);
    bit [15:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) seen[(v >> (4 * i)) & 16'hF] = 1'b1;
    return ($countones(seen[9:0]) == 4) && (seen[15:10] == '0);
  endfunction

  function automatic logic [15:0] rand_secret();
    int pool[$];
    int k;
    logic [15:0] v;
    v = '0;
    for (int d = 0; d < 10; d++) pool.push_back(d);
    for (int i = 0; i < 4; i++) begin
      k = int'($urandom_range(pool.size() - 1));
      v = {v[11:0], 4'(pool[k])};
      pool.delete(k);
    end
    return v;
  endfunction

  task automatic do_load(input logic [15:0] s);
    gif.secret_load = 1'b1;
    gif.secret_in   = s;
    @(negedge clk);
    gif.secret_load = 1'b0;
  endtask

  task automatic do_digit(input logic [3:0] d);
    gif.digit_valid = 1'b1;
    gif.digit_in    = d;
    @(negedge clk);
    gif.digit_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (gif.busy !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, gif.busy, 0);
  endtask

  task automatic play_guess(input logic [15:0] g);
    int ea, eb;
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 4'((g >> (12 - 4 * i)) & 16'hF);
      do_digit(d);
      chk("digit_reject", gif.reject, 0);
      chk("digit_disp", gif.disp_digit, d);
    end
    gif.commit = 1'b1;
    @(negedge clk);
    gif.commit = 1'b0;
    model_score(m_secret, g, ea, eb);
    if (m_gcnt < 99) m_gcnt++;
    chk("rv_pulse", gif.result_valid, 1);
    chk("a_count", gif.a_count, ea);
    chk("b_count", gif.b_count, eb);
    @(negedge clk);
    chk("rv_single", gif.result_valid, 0);
    chk("guess_cnt", gif.guess_cnt, m_gcnt);
    chk("win", gif.win, (ea == 4));
    chk("disp_after", gif.disp_digit, (ea == 4) ? {28'd0, g[3:0]} : 32'hF);
    chk("busy_after", gif.busy, 0);
  endtask

  initial begin
    logic [15:0] g;
    gif.digit_valid = 1'b0;
    gif.digit_in    = '0;
    gif.commit      = 1'b0;
    gif.clear       = 1'b0;
    gif.new_game    = 1'b0;
    gif.secret_load = 1'b0;
    gif.secret_in   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_disp", gif.disp_digit, 32'hF);
    chk("rst_busy", gif.busy, 1);
    chk("rst_ab", {gif.a_count, gif.b_count}, 0);
    chk("rst_flags", {gif.result_valid, gif.win, gif.reject}, 0);
    chk("rst_gcnt", gif.guess_cnt, 0);
    chk("rst_secret", gif.secret_out, 0);
    rst_n = 1'b1;
    wait_ready("gen_done");
    chk("gen_valid", model_valid(gif.secret_out), 1);
    chk("gen_disp", gif.disp_digit, 32'hF);

    // Full mismatch of position, all digits present.
    do_load(16'h1234); m_secret = 16'h1234; m_gcnt = 0;
    chk("load_secret", gif.secret_out, 32'h1234);
    play_guess(16'h4321);

    // Winning guess, then WIN ignores input.
    do_load(16'h1234); m_gcnt = 0;
    play_guess(16'h1234);
    do_digit(4'd5);
    chk("win_no_reject", gif.reject, 0);
    chk("win_disp", gif.disp_digit, 4);
    gif.commit = 1'b1; @(negedge clk); gif.commit = 1'b0;
    chk("win_no_result", gif.result_valid, 0);

    // Rejects, short commit, clear.
    do_load(16'h5678); m_secret = 16'h5678; m_gcnt = 0;
    do_digit(4'd5);
    chk("first5_ok", gif.reject, 0);
    do_digit(4'd5);
    chk("dup_reject", gif.reject, 1);
    @(negedge clk);
    chk("reject_single", gif.reject, 0);
    do_digit(4'hB);
    chk("bad_digit_reject", gif.reject, 1);
    chk("bad_digit_disp", gif.disp_digit, 5);
    gif.commit = 1'b1; @(negedge clk); gif.commit = 1'b0;
    chk("short_commit", gif.result_valid, 0);
    gif.clear = 1'b1; @(negedge clk); gif.clear = 1'b0;
    chk("clear_disp", gif.disp_digit, 32'hF);
    play_guess(16'h8765);

    // Invalid load ignored; load beats new_game and digit_valid.
    do_load(16'h1123);
    chk("bad_load_ignored", gif.secret_out, 32'h5678);
    gif.secret_load = 1'b1; gif.secret_in = 16'h4321;
    gif.new_game = 1'b1; gif.digit_valid = 1'b1; gif.digit_in = 4'd7;
    @(negedge clk);
    gif.secret_load = 1'b0; gif.new_game = 1'b0; gif.digit_valid = 1'b0;
    m_secret = 16'h4321; m_gcnt = 0;
    chk("prio_secret", gif.secret_out, 32'h4321);
    chk("prio_busy", gif.busy, 0);
    chk("prio_reject", gif.reject, 0);
    chk("prio_disp", gif.disp_digit, 32'hF);
    chk("prio_gcnt", gif.guess_cnt, 0);
    play_guess(16'h1234);

    // Randomized games against the reference model.
    for (int t = 0; t < 6; t++) begin
      m_secret = rand_secret();
      m_gcnt = 0;
      do_load(m_secret);
      chk("rand_load", gif.secret_out, m_secret);
      for (int k = 0; k < 3; k++) begin
        g = rand_secret();
        if (g == m_secret) g = {g[3:0], g[15:4]};
        play_guess(g);
      end
    end

    // Saturation then new game.
    do_load(16'h1234); m_secret = 16'h1234; m_gcnt = 0;
    for (int k = 0; k < 100; k++) play_guess(16'h5678);
    chk("sat_gcnt", gif.guess_cnt, 99);
    gif.new_game = 1'b1; @(negedge clk); gif.new_game = 1'b0;
    chk("ng_gcnt", gif.guess_cnt, 0);
    chk("ng_busy", gif.busy, 1);
    chk("ng_disp", gif.disp_digit, 32'hF);
    wait_ready("ng_gen_done");
    chk("ng_valid", model_valid(gif.secret_out), 1);
    chk("ng_differs", (gif.secret_out != m_secret), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
